// File: rtl/serial_add_sequencer.sv
// Parallel-to-serial front end for the bit-serial adder: shifts operands out LSB-first, gathers ser_sum into a result.
// Optional build macro SERIAL_ADD_SEQ_BUBBLE_EN inserts an idle cycle after every non-final serial bit.
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_sum
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_rdy_q, in_rdy_d;
    logic             ser_vld_q, ser_vld_d;
    logic             ser_a_q, ser_a_d;
    logic             ser_b_q, ser_b_d;
    logic             ser_last_q, ser_last_d;
    logic             out_vld_q, out_vld_d;
    logic             bubble;

    // Next-state, datapath and registered-output decode; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_vld && in_rdy_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // ser_sum is only meaningful on a valid bit; bubble cycles hold everything.
                if (ser_vld_q) begin
                    sum_d = (sum_q >> 1) | (WIDTH'(ser_sum) << (WIDTH - 1));
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (ser_last_q) begin
                        state_d = DONE;
                    end else begin
`ifdef SERIAL_ADD_SEQ_BUBBLE_EN
                        bubble = 1'b1;
`else
                        bubble = 1'b0;
`endif
                    end
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_rdy_d   = (state_d == IDLE);
        ser_vld_d  = (state_d == SHIFT) && !bubble;
        ser_a_d    = ser_vld_d && a_d[0];
        ser_b_d    = ser_vld_d && b_d[0];
        ser_last_d = ser_vld_d && (cnt_d == CNT_LAST);
        out_vld_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            in_rdy_q   <= 1'b1;
            ser_vld_q  <= 1'b0;
            ser_a_q    <= 1'b0;
            ser_b_q    <= 1'b0;
            ser_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            in_rdy_q   <= in_rdy_d;
            ser_vld_q  <= ser_vld_d;
            ser_a_q    <= ser_a_d;
            ser_b_q    <= ser_b_d;
            ser_last_q <= ser_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign in_rdy   = in_rdy_q;
    assign ser_vld  = ser_vld_q;
    assign ser_a    = ser_a_q;
    assign ser_b    = ser_b_q;
    assign ser_last = ser_last_q;
    assign out_vld  = out_vld_q;
    assign out_sum  = sum_q;

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Parallel-side front end for the bit-serial adder.
- Accepts two WIDTH-bit operands on a valid/ready handshake and drives them LSB-first onto the serial interface (ser_vld, ser_a, ser_b, ser_last).
- Collects the returned ser_sum bits and presents the WIDTH-bit result on a valid/ready output handshake.
- One operation in flight at a time; sits between a parallel producer/consumer and the serial adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_vld  input  1  operand pair valid.
- in_rdy  output  1  sequencer can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- ser_vld  output  1  serial bit valid, to adder vld.
- ser_a  output  1  serial bit of A, to adder a.
- ser_b  output  1  serial bit of B, to adder b.
- ser_last  output  1  final bit of frame, to adder last.
- ser_sum  input  1  sum bit from adder; combinational response to the current ser_a/ser_b.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out_sum  output  WIDTH  result, (in_a + in_b) mod 2^WIDTH.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: in_rdy=1, ser_vld=0, ser_a=0, ser_b=0, ser_last=0, out_vld=0, out_sum=0.
- Reset counter and shift registers clear to 0.
- IDLE:
  - in_rdy=1; all ser_* outputs are 0.
  - On in_vld&in_rdy, latch in_a/in_b into shift registers, clear bit counter, go to SHIFT.
- SHIFT:
  - in_rdy=0 and ser_vld=1.
  - ser_a = a_shift[0], ser_b = b_shift[0].
  - ser_last = (cnt == WIDTH-1).
  - Each cycle: shift ser_sum into the result register at the MSB, shifting right; shift operand registers right; cnt increments.
  - On the ser_last cycle, go to DONE.
- DONE:
  - out_vld=1 and out_sum holds the result, stable until accepted.
  - On out_rdy, go to IDLE in the same edge; out_vld drops the next cycle.
- Latency:
  - Operands accepted at edge 0.
  - Serial bits occupy cycles 1..WIDTH.
  - out_vld is high from cycle WIDTH+1.
  - Next operands are accepted no earlier than the cycle after the result handshake; throughput is one op per WIDTH+2 cycles with out_rdy held high.
- ser_last is never high while ser_vld is low, so the adder's carry clears exactly once per frame.
- WIDTH=1: the single SHIFT cycle has ser_last=1.
- in_vld while busy: ignored (in_rdy=0); in_a/in_b are not sampled.
- out_rdy while not out_vld: ignored.
- Result arithmetic:
  - Carry out of the MSB is discarded (mod 2^WIDTH).
  - The sequencer performs no addition itself and relies on ser_sum.
- Reset mid-operation:
  - Immediately returns to IDLE and clears all outputs; the partial frame is abandoned and no out_vld is produced.
  - The adder shares rst, so its carry is cleared too.
- ser_sum is only sampled when ser_vld=1.

Optional Feature:
- SERIAL_ADD_SEQ_BUBBLE_EN defined:
  - SHIFT inserts one idle cycle after every valid bit.
  - During an idle cycle, ser_vld=0, ser_a=ser_b=ser_last=0, and no shift or count occurs.
  - Exercises the adder's vld-gating; the frame takes 2*WIDTH cycles (bubble after the final bit omitted, so 2*WIDTH-1 serial cycles).
  - out_vld is high from cycle 2*WIDTH.
- Not defined: no bubbles, timing as above.
- Result value is identical in both builds.

Test Plan:
- WIDTH=8, in_a=0x35, in_b=0x0A, out_rdy=1 -> ser_vld high for cycles 1..8, ser_last only at cycle 8, out_vld at cycle 9, out_sum=0x3F.
- in_a=0xFF, in_b=0x01 -> out_sum=0x00 (carry discarded); next op 0x01+0x01 -> 0x02, proving the carry cleared between frames.
- Back-to-back ops 0x10+0x20 then 0x7F+0x01 with out_rdy low for 5 cycles after the first out_vld -> out_sum holds 0x30, in_rdy=0 throughout the stall; second result 0x80.
- in_vld pulsed with 0xAA/0x55 during SHIFT of op 0x03+0x04 -> ignored; out_sum=0x07, no second result.
- rst asserted asynchronously at cycle 4 of op 0xF0+0x0F -> outputs zero immediately, no out_vld; subsequent op 0x01+0x02 -> 0x03.
- With SERIAL_ADD_SEQ_BUBBLE_EN, op 0x35+0x0A -> ser_vld alternates 1/0, ser_last on the 8th valid bit, out_sum=0x3F at cycle 16.
